capture_controller: RTL and testbench
=====================================

CAPTURE_CONTROLLER -- requirements
Module: capture_controller

Interface
REQ-001 SHALL have parameter CHANNEL_COUNT, default 8: number of analyzer channels.
REQ-002 SHALL have parameter SAMPLE_BUFF_SIZE, default 640: samples per capture (per-channel shift-register depth).
REQ-003 SHALL have parameter DIV_WIDTH, default 16: sample-divider width.
REQ-004 clk  input  1  clock; all state changes on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 arm  input  1  start request, sampled each clock.
REQ-007 abort  input  1  cancel request, sampled each clock.
REQ-008 sample_div  input  DIV_WIDTH  sample period minus one, in clk cycles.
REQ-009 chan_in  input  CHANNEL_COUNT  probe inputs, already synchronized to clk.
REQ-010 trig_mask  input  CHANNEL_COUNT  1 = channel participates in trigger.
REQ-011 trig_level  input  CHANNEL_COUNT  required level per masked channel.
REQ-012 trig_edge  input  1  0 = level trigger, 1 = edge (entry into match) trigger.
REQ-013 shift  output  1  one-cycle shift strobe to all channel shift registers.
REQ-014 s_in  output  CHANNEL_COUNT  serial data per channel, valid while shift=1.
REQ-015 busy  output  1  high in ARMED or CAPTURE.
REQ-016 done  output  1  high in DONE.
REQ-017 state  output  2  IDLE=0, ARMED=1, CAPTURE=2, DONE=3.
REQ-018 sample_count  output  clog2(SAMPLE_BUFF_SIZE+1)  samples shifted in the current capture.

Function
REQ-019 Divider SHALL count 0..sample_div and assert internal tick in the cycle where count==sample_div, then return to 0; sample_div=0 SHALL give a tick every cycle.
REQ-020 Divider SHALL be held at 0 in IDLE and DONE, and SHALL restart from 0 on entry to ARMED.
REQ-021 Trigger match SHALL be ((chan_in XOR trig_level) AND trig_mask)==0; trig_mask=0 SHALL always match.
REQ-022 Edge mode SHALL fire on a tick where match=1 and match at previous tick=0; previous-match register SHALL be set to 1 on arm, so the first tick after arm never edge-fires.
REQ-023 IDLE/DONE + arm: next state ARMED, sample_count cleared to 0, done cleared.
REQ-024 ARMED + tick with trigger fired: the edge SHALL register that tick's sample (shift<=1, s_in<=chan_in, sample_count<=1) and go to CAPTURE.
REQ-025 CAPTURE + tick: shift<=1, s_in<=chan_in, sample_count incremented; when incremented value equals SAMPLE_BUFF_SIZE, go to DONE at the same edge.
REQ-026 shift SHALL be high for exactly one cycle per captured sample and low otherwise; s_in SHALL hold its last value when shift=0.
REQ-027 Exactly SAMPLE_BUFF_SIZE shift strobes SHALL occur per completed capture; DONE SHALL hold until arm, abort or reset.
REQ-028 arm in ARMED or CAPTURE SHALL be ignored.
REQ-029 abort in any state SHALL go to IDLE at next edge, force shift=0 and clear sample_count; abort and arm in the same cycle: abort wins.

Reset
REQ-030 On reset: state=IDLE, shift=0, s_in=0, busy=0, done=0, sample_count=0, divider=0, previous-match=1, asynchronously.
REQ-031 Reset mid-capture SHALL discard the capture; no shift strobe after reset assertion.

Configuration
REQ-032 With macro LA_TRIGGER_EN defined, trigger SHALL behave per REQ-021/022/024.
REQ-033 Without LA_TRIGGER_EN, ARMED SHALL go to CAPTURE on the first tick unconditionally, capturing that sample; trig_mask, trig_level, trig_edge SHALL remain ports but be ignored.

Verification
REQ-034 SAMPLE_BUFF_SIZE=8, sample_div=0, trig_mask=0, arm pulse -> shift high 8 consecutive cycles starting 2 cycles after arm, then done=1, state=3, sample_count=8.
REQ-035 sample_div=3, mask=0x01, level=0x01, level mode, chan_in[0] rises at cycle 20 -> first shift after first tick with chan_in[0]=1, strobes every 4 cycles thereafter.
REQ-036 Edge mode, chan_in[0] already 1 at arm -> no trigger until chan_in[0] falls then rises; first captured sample has bit0=1.
REQ-037 abort asserted after 3 of 8 samples -> state=0 next cycle, sample_count=0, no further shift; arm+abort same cycle -> stays IDLE.
REQ-038 Reset asserted during CAPTURE -> all outputs 0 immediately; re-arm yields full 8-sample capture.
REQ-039 Build without LA_TRIGGER_EN, mask=0xFF, level mismatching -> capture still starts on first tick.

Source files
------------

// File: rtl/capture_controller.sv
// ---------------------------------------------------------------------------
// capture_controller
//
// Sequencing core of a logic analyzer. It waits for an arm request, paces
// sampling with a programmable clock divider, optionally waits for a trigger
// condition on the probe inputs, and then streams exactly SAMPLE_BUFF_SIZE
// samples into the per-channel shift registers. Each sample is one cycle of
// the `shift` strobe together with the sampled `s_in` word.
//
// Build option:
//   LA_TRIGGER_EN  defined   -> level/edge trigger on masked channels
//                  undefined -> capture starts on the first divider tick
//                               after arm; trigger ports are accepted but
//                               ignored
//
// Parameters:
//   CHANNEL_COUNT     number of analyzer channels
//   SAMPLE_BUFF_SIZE  samples per capture (shift-register depth)
//   DIV_WIDTH         width of the sample divider
//
// Ports:
//   clk           clock, rising edge
//   reset         asynchronous, active-high reset
//   arm           start request (honoured in IDLE and DONE)
//   abort         cancel request, any state, beats arm
//   sample_div    sample period minus one, in clk cycles
//   chan_in       probe inputs, already synchronous to clk
//   trig_mask     1 = channel takes part in the trigger
//   trig_level    required level per masked channel
//   trig_edge     0 = level trigger, 1 = trigger on entry into match
//   shift         one-cycle strobe per captured sample
//   s_in          sample word, valid while shift=1, held otherwise
//   busy          high in ARMED or CAPTURE
//   done          high in DONE
//   state         IDLE=0, ARMED=1, CAPTURE=2, DONE=3
//   sample_count  samples shifted in the current capture
// ---------------------------------------------------------------------------
module capture_controller #(
  parameter int CHANNEL_COUNT    = 8,
  parameter int SAMPLE_BUFF_SIZE = 640,
  parameter int DIV_WIDTH        = 16,
  localparam int CNT_WIDTH       = $clog2(SAMPLE_BUFF_SIZE + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     arm,
  input  logic                     abort,
  input  logic [DIV_WIDTH-1:0]     sample_div,
  input  logic [CHANNEL_COUNT-1:0] chan_in,
  input  logic [CHANNEL_COUNT-1:0] trig_mask,
  input  logic [CHANNEL_COUNT-1:0] trig_level,
  input  logic                     trig_edge,
  output logic                     shift,
  output logic [CHANNEL_COUNT-1:0] s_in,
  output logic                     busy,
  output logic                     done,
  output logic [1:0]               state,
  output logic [CNT_WIDTH-1:0]     sample_count
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(SAMPLE_BUFF_SIZE);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [DIV_WIDTH-1:0] DIV_ONE  = DIV_WIDTH'(1);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_e                     state_q, state_d;
  logic [DIV_WIDTH-1:0]       div_q, div_d;
  logic [CNT_WIDTH-1:0]       cnt_q, cnt_d;
  logic                       shift_q, shift_d;
  logic [CHANNEL_COUNT-1:0]   s_in_q, s_in_d;

  logic                       running;
  logic                       tick;
  logic                       fire;
  logic [CNT_WIDTH-1:0]       cnt_inc;

  // The divider only runs while a capture is in progress; in IDLE/DONE it is
  // parked at zero so that arming always starts a fresh sample period.
  assign running = (state_q == ST_ARMED) || (state_q == ST_CAPTURE);
  assign tick    = running && (div_q == sample_div);
  assign cnt_inc = cnt_q + CNT_ONE;

`ifdef LA_TRIGGER_EN
  // Match of the previous tick, for edge mode. Preset to 1 on arm so that a
  // condition already true when arming is not mistaken for a fresh edge.
  logic prev_match_q, prev_match_d;
  logic match;

  assign match = ((chan_in ^ trig_level) & trig_mask) == '0;
  assign fire  = tick && (trig_edge ? (match && !prev_match_q) : match);
`else
  // Trigger inputs stay on the port list for a uniform interface but carry
  // no function in this build.
  logic unused_trig;

  assign unused_trig = ^{trig_mask, trig_level, trig_edge};
  assign fire        = tick;
`endif

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      div_q        <= '0;
      cnt_q        <= '0;
      shift_q      <= 1'b0;
      s_in_q       <= '0;
`ifdef LA_TRIGGER_EN
      prev_match_q <= 1'b1;
`endif
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      s_in_q       <= s_in_d;
`ifdef LA_TRIGGER_EN
      prev_match_q <= prev_match_d;
`endif
    end
  end

  // -------------------------------------------------------------------------
  // Next-state and datapath logic
  // -------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default before any branch, which
  // keeps the block purely combinational (no inferred latches).
  always_comb begin
    state_d      = state_q;
    div_d        = div_q;
    cnt_d        = cnt_q;
    shift_d      = 1'b0;          // strobe is a single-cycle pulse
    s_in_d       = s_in_q;        // sample word holds between strobes
`ifdef LA_TRIGGER_EN
    prev_match_d = prev_match_q;
`endif

    if (abort) begin
      // Abort dominates everything, including a simultaneous arm.
      state_d = ST_IDLE;
      div_d   = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          div_d = '0;
          if (arm) begin
            state_d      = ST_ARMED;
            cnt_d        = '0;
`ifdef LA_TRIGGER_EN
            prev_match_d = 1'b1;
`endif
          end
        end

        ST_ARMED: begin
          div_d = tick ? '0 : div_q + DIV_ONE;
`ifdef LA_TRIGGER_EN
          if (tick) begin
            prev_match_d = match;
          end
`endif
          // The triggering tick is itself the first captured sample.
          if (fire) begin
            shift_d = 1'b1;
            s_in_d  = chan_in;
            cnt_d   = CNT_ONE;
            state_d = (CNT_ONE == CNT_LAST) ? ST_DONE : ST_CAPTURE;
          end
        end

        ST_CAPTURE: begin
          div_d = tick ? '0 : div_q + DIV_ONE;
          if (tick) begin
            shift_d = 1'b1;
            s_in_d  = chan_in;
            cnt_d   = cnt_inc;
            if (cnt_inc == CNT_LAST) begin
              state_d = ST_DONE;
            end
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign shift        = shift_q;
  assign s_in         = s_in_q;
  assign busy         = running;
  assign done         = (state_q == ST_DONE);
  assign state        = state_q;
  assign sample_count = cnt_q;

endmodule

// File: tb/tb_capture_controller.sv
// ---------------------------------------------------------------------------
// tb_capture_controller
//
// Drives capture_controller (SAMPLE_BUFF_SIZE=8) through a table of capture
// scenarios plus hand-written abort and reset sequences. Each table row gives
// the divider/trigger setup, a stimulus pattern and the hand-derived cycle
// offset of the first captured sample for both builds. Expected samples are
// queued as they are driven; a monitor pops one per observed strobe and checks
// data, sample count and the cycle it appeared in.
// ---------------------------------------------------------------------------
module tb_capture_controller;

  localparam int NCH = 8;
  localparam int NS  = 8;
  localparam int DW  = 16;
  localparam int CW  = $clog2(NS + 1);

  logic           clk        = 1'b0;
  logic           reset      = 1'b1;
  logic           arm        = 1'b0;
  logic           abort      = 1'b0;
  logic [DW-1:0]  sample_div = '0;
  logic [NCH-1:0] chan_in    = '0;
  logic [NCH-1:0] trig_mask  = '0;
  logic [NCH-1:0] trig_level = '0;
  logic           trig_edge  = 1'b0;
  logic           shift;
  logic [NCH-1:0] s_in;
  logic           busy;
  logic           done;
  logic [1:0]     state;
  logic [CW-1:0]  sample_count;

  capture_controller #(
    .CHANNEL_COUNT    (NCH),
    .SAMPLE_BUFF_SIZE (NS),
    .DIV_WIDTH        (DW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .arm          (arm),
    .abort        (abort),
    .sample_div   (sample_div),
    .chan_in      (chan_in),
    .trig_mask    (trig_mask),
    .trig_level   (trig_level),
    .trig_edge    (trig_edge),
    .shift        (shift),
    .s_in         (s_in),
    .busy         (busy),
    .done         (done),
    .state        (state),
    .sample_count (sample_count)
  );

  always #5 clk = ~clk;

  // Rising-edge counter; outputs are sampled on the falling edge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // -------------------------------------------------------------------------
  // Scoreboard
  // -------------------------------------------------------------------------
  typedef struct {
    logic [NCH-1:0] val;
    int             cnt;
    int             at;
  } exp_t;

  exp_t           exp_q[$];
  exp_t           mon_e;
  logic [NCH-1:0] hold_val = '0;

  always @(negedge clk) begin
    if (reset) begin
      hold_val = '0;
      check("shift_in_reset", {31'd0, shift}, 32'd0);
    end else if (shift) begin
      if (exp_q.size() == 0) begin
        check("unexpected_shift", {31'd0, shift}, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("s_in", {24'd0, s_in}, {24'd0, mon_e.val});
        check("sample_count", {28'd0, sample_count}, mon_e.cnt);
        check("strobe_cycle", cyc, mon_e.at);
        hold_val = mon_e.val;
      end
    end else begin
      check("s_in_hold", {24'd0, s_in}, {24'd0, hold_val});
    end
  end

  // -------------------------------------------------------------------------
  // Scenario table
  // -------------------------------------------------------------------------
  typedef struct {
    string          name;
    int             div;
    logic [NCH-1:0] mask;
    logic [NCH-1:0] level;
    logic           edge_mode;
    int             kind;       // stimulus pattern
    int             arm_at;     // offset of an extra (ignored) arm, -1 none
    int             j_trig;     // first capture offset, trigger build (-1 never)
    int             j_free;     // first capture offset, untriggered build
  } scen_t;

  scen_t          tbl[8];
  logic [NCH-1:0] stim[0:63];

  task automatic run_scen(input scen_t sc);
    int            jf;
    int            last;
    int            c0;
    logic [31:0]   rnd;
`ifdef LA_TRIGGER_EN
    jf = sc.j_trig;
`else
    jf = sc.j_free;
`endif
    last = (jf >= 0) ? jf + (NS - 1) * (sc.div + 1) : 40;

    for (int j = 0; j < 64; j++) begin
      rnd = $urandom;
      case (sc.kind)
        1:       stim[j] = {rnd[7:1], (j >= 9)};
        2:       stim[j] = {rnd[7:1], ((j < 6) || (j >= 10))};
        3:       stim[j] = {rnd[7:1], 1'b0} ^ 8'h55;
        4:       stim[j] = (j >= 4) ? {rnd[7:4], 4'h5} : {rnd[7:4], 4'hA};
        default: stim[j] = rnd[7:0];
      endcase
    end

    @(negedge clk);
    sample_div = DW'(sc.div);
    trig_mask  = sc.mask;
    trig_level = sc.level;
    trig_edge  = sc.edge_mode;
    chan_in    = 8'($urandom);
    arm        = 1'b1;
    c0         = cyc;

    for (int j = 0; j <= last; j++) begin
      @(negedge clk);
      arm     = (j == sc.arm_at);
      chan_in = stim[j];
      if (j == 0) begin
        check({sc.name, "_armed_state"}, {30'd0, state}, 32'd1);
        check({sc.name, "_armed_busy"}, {31'd0, busy}, 32'd1);
        check({sc.name, "_armed_done"}, {31'd0, done}, 32'd0);
        check({sc.name, "_armed_count"}, {28'd0, sample_count}, 32'd0);
      end
      if (jf >= 0 && j >= jf && ((j - jf) % (sc.div + 1)) == 0)
        exp_q.push_back('{val: stim[j], cnt: (j - jf) / (sc.div + 1) + 1,
                          at: c0 + 2 + j});
    end

    @(negedge clk);
    arm = 1'b0;
    if (jf >= 0) begin
      check({sc.name, "_done_state"}, {30'd0, state}, 32'd3);
      check({sc.name, "_done_flag"}, {31'd0, done}, 32'd1);
      check({sc.name, "_done_busy"}, {31'd0, busy}, 32'd0);
      check({sc.name, "_done_count"}, {28'd0, sample_count}, NS);
      repeat (3) @(negedge clk);
      check({sc.name, "_done_hold"}, {30'd0, state}, 32'd3);
      check({sc.name, "_drained"}, exp_q.size(), 32'd0);
    end else begin
      check({sc.name, "_still_armed"}, {30'd0, state}, 32'd1);
      check({sc.name, "_still_busy"}, {31'd0, busy}, 32'd1);
      check({sc.name, "_no_samples"}, {28'd0, sample_count}, 32'd0);
      check({sc.name, "_drained"}, exp_q.size(), 32'd0);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check({sc.name, "_abort_armed"}, {30'd0, state}, 32'd0);
    end
  endtask

  // -------------------------------------------------------------------------
  // Main sequence
  // -------------------------------------------------------------------------
  initial begin
    int c0;

    //        name              div mask   level  edge kind arm_at trig free
    tbl[0] = '{"basic",          0, 8'h00, 8'h00, 1'b0, 0, -1,  0, 0};
    tbl[1] = '{"arm_in_capture", 0, 8'h00, 8'h00, 1'b0, 0,  4,  0, 0};
    tbl[2] = '{"level_rise",     3, 8'h01, 8'h01, 1'b0, 1,  2, 11, 3};
    tbl[3] = '{"edge_refire",    1, 8'h01, 8'h01, 1'b1, 2, -1, 11, 1};
    tbl[4] = '{"mismatch",       2, 8'hFF, 8'hAA, 1'b0, 3, -1, -1, 2};
    tbl[5] = '{"edge_mask0",     0, 8'h00, 8'h00, 1'b1, 0, -1, -1, 0};
    tbl[6] = '{"nibble_level",   0, 8'h0F, 8'h05, 1'b0, 4, -1,  4, 0};
    tbl[7] = '{"div2_basic",     2, 8'h00, 8'h00, 1'b0, 0, -1,  2, 2};

    // Reset state.
    #1;
    check("rst_state", {30'd0, state}, 32'd0);
    check("rst_shift", {31'd0, shift}, 32'd0);
    check("rst_s_in", {24'd0, s_in}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_count", {28'd0, sample_count}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    for (int s = 0; s < 8; s++) run_scen(tbl[s]);

    // Abort from DONE.
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_done_state", {30'd0, state}, 32'd0);
    check("abort_done_flag", {31'd0, done}, 32'd0);

    // Abort after three of eight samples.
    @(negedge clk);
    sample_div = '0;
    trig_mask  = '0;
    trig_edge  = 1'b0;
    arm        = 1'b1;
    c0         = cyc;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      arm     = 1'b0;
      chan_in = 8'($urandom);
      if (j < 3) exp_q.push_back('{val: chan_in, cnt: j + 1, at: c0 + 2 + j});
      else       abort = 1'b1;
    end
    @(negedge clk);
    abort = 1'b0;
    check("abort_cap_state", {30'd0, state}, 32'd0);
    check("abort_cap_count", {28'd0, sample_count}, 32'd0);
    check("abort_cap_shift", {31'd0, shift}, 32'd0);
    check("abort_cap_busy", {31'd0, busy}, 32'd0);
    repeat (5) @(negedge clk);
    check("abort_cap_idle", {30'd0, state}, 32'd0);
    check("abort_cap_drained", exp_q.size(), 32'd0);

    // Arm and abort together: abort wins.
    arm   = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    arm   = 1'b0;
    abort = 1'b0;
    check("arm_abort_state", {30'd0, state}, 32'd0);
    repeat (4) @(negedge clk);
    check("arm_abort_idle", {30'd0, state}, 32'd0);

    // Reset in the middle of a capture.
    arm = 1'b1;
    c0  = cyc;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      arm     = 1'b0;
      chan_in = 8'($urandom);
      exp_q.push_back('{val: chan_in, cnt: j + 1, at: c0 + 2 + j});
    end
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("rst_cap_state", {30'd0, state}, 32'd0);
    check("rst_cap_shift", {31'd0, shift}, 32'd0);
    check("rst_cap_s_in", {24'd0, s_in}, 32'd0);
    check("rst_cap_busy", {31'd0, busy}, 32'd0);
    check("rst_cap_done", {31'd0, done}, 32'd0);
    check("rst_cap_count", {28'd0, sample_count}, 32'd0);
    check("rst_cap_drained", exp_q.size(), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    run_scen(tbl[0]);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
